// File: rtl/multi_cycle_control_if.sv
// rtl/multi_cycle_control_if.sv - control/status bundle between the multi-cycle controller and its datapath.
// Optional MC_ILLEGAL_TRAP_EN adds the illegal_inst flag.
interface multi_cycle_control_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       ecall_halt;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       is_ecall;
  logic       is_halted;
  logic       inst_retired;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_inst;
`endif

  modport master (
    input  opcode, bcond, ecall_halt, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg, pc_to_reg, pc_write, pc_src,
           is_ecall, is_halted, inst_retired
`ifdef MC_ILLEGAL_TRAP_EN
    , illegal_inst
`endif
  );

  modport slave (
    output opcode, bcond, ecall_halt, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg, pc_to_reg, pc_write, pc_src,
           is_ecall, is_halted, inst_retired
`ifdef MC_ILLEGAL_TRAP_EN
    , illegal_inst
`endif
  );
endinterface

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle RV32 control FSM (IF/ID/EX/MEM/WB/HALT).
// Define MC_ILLEGAL_TRAP_EN to halt on unrecognized opcodes instead of treating them as NOPs.
module multi_cycle_control (
  input logic                   clk,
  input logic                   reset_n,
  multi_cycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  state_t     state;
  logic [6:0] op_q;
  logic [6:0] cur_op;

  logic is_arith, is_arith_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_sys;
  logic known_op;

  // ID decodes the live instruction-register opcode; later states use the latched copy.
  assign cur_op       = (state == S_ID) ? bus.opcode : op_q;
  assign is_arith     = (cur_op == OP_ARITH);
  assign is_arith_imm = (cur_op == OP_ARITH_IMM);
  assign is_load      = (cur_op == OP_LOAD);
  assign is_store     = (cur_op == OP_STORE);
  assign is_branch    = (cur_op == OP_BRANCH);
  assign is_jal       = (cur_op == OP_JAL);
  assign is_jalr      = (cur_op == OP_JALR);
  assign is_sys       = (cur_op == OP_SYSTEM);
  assign known_op     = is_arith | is_arith_imm | is_load | is_store | is_branch |
                        is_jal | is_jalr | is_sys;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IF;
      op_q  <= '0;
    end else begin
      case (state)
        S_IF: begin
          if (bus.mem_ready) state <= S_ID;
        end
        S_ID: begin
          op_q <= bus.opcode;
          if (is_sys) begin
            state <= bus.ecall_halt ? S_HALT : S_IF;
          end else if (known_op) begin
            state <= S_EX;
          end else begin
`ifdef MC_ILLEGAL_TRAP_EN
            state <= S_HALT;
`else
            state <= S_IF;
`endif
          end
        end
        S_EX: begin
          if (is_load || is_store) state <= S_MEM;
          else if (is_branch)      state <= S_IF;
          else                     state <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) state <= is_load ? S_WB : S_IF;
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  logic       mem_read, mem_write, i_or_d, ir_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       reg_write, mem_to_reg, pc_to_reg, pc_write;
  logic       is_ecall, is_halted, illegal;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    is_ecall   = 1'b0;
    is_halted  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = bus.mem_ready;
      end
      S_ID: begin
        if (is_sys) begin
          is_ecall = 1'b1;
          pc_write = ~bus.ecall_halt;
        end else if (!known_op) begin
`ifdef MC_ILLEGAL_TRAP_EN
          illegal  = 1'b1;
`else
          pc_write = 1'b1;
`endif
        end
      end
      S_EX: begin
        if (is_arith || is_arith_imm) begin
          alu_src_a = 1'b1;
          alu_src_b = is_arith_imm ? 2'b10 : 2'b00;
          alu_op    = 2'b10;
        end else if (is_load || is_store) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end else if (is_branch) begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_write  = 1'b1;
          pc_src    = bus.bcond ? 2'b01 : 2'b00;
        end else begin
          // Jumps: form PC+4 for the link value.
          alu_src_b = 2'b01;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_load;
        mem_write = ~is_load;
        pc_write  = ~is_load & bus.mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (is_load) begin
          mem_to_reg = 1'b1;
        end else if (is_jal || is_jalr) begin
          pc_to_reg = 1'b1;
          pc_src    = is_jal ? 2'b01 : 2'b10;
        end
      end
      S_HALT: is_halted = 1'b1;
      default: ;
    endcase
  end

  // Reset must silence every output immediately, even though IF would otherwise drive mem_read.
  assign bus.mem_read     = reset_n & mem_read;
  assign bus.mem_write    = reset_n & mem_write;
  assign bus.i_or_d       = reset_n & i_or_d;
  assign bus.ir_write     = reset_n & ir_write;
  assign bus.alu_src_a    = reset_n & alu_src_a;
  assign bus.alu_src_b    = {2{reset_n}} & alu_src_b;
  assign bus.alu_op       = {2{reset_n}} & alu_op;
  assign bus.reg_write    = reset_n & reg_write;
  assign bus.mem_to_reg   = reset_n & mem_to_reg;
  assign bus.pc_to_reg    = reset_n & pc_to_reg;
  assign bus.pc_write     = reset_n & pc_write;
  assign bus.pc_src       = {2{reset_n}} & pc_src;
  assign bus.is_ecall     = reset_n & is_ecall;
  assign bus.is_halted    = reset_n & is_halted;
  assign bus.inst_retired = reset_n & pc_write;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal_inst = reset_n & illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - directed and randomized checks of multi_cycle_control against a per-instruction cycle model.
module tb_multi_cycle_control;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, SYS = 7'b1110011;
  localparam logic [17:0] ALL = 18'h3FFFF;
  localparam logic [17:0] ALU = 18'h03E00;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  multi_cycle_control_if b ();
  multi_cycle_control dut (.clk(clk), .reset_n(reset_n), .bus(b.master));

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    bit         ready;
    logic [6:0] opc;
    bit         bc;
    bit         eh;
    logic [17:0] exp;
    logic [17:0] mask;
    bit         ill;
  } cyc_t;

  cyc_t q[$];

  // Bit order: mr mw iod irw asa asb[2] aop[2] rw m2r p2r pw ps[2] ec hl retired(=pw).
  function automatic logic [17:0] ev(bit mr, bit mw, bit iod, bit irw, bit asa, bit [1:0] asb,
                                     bit [1:0] aop, bit rw, bit m2r, bit p2r, bit pw,
                                     bit [1:0] ps, bit ec, bit hl);
    return {mr, mw, iod, irw, asa, asb, aop, rw, m2r, p2r, pw, ps, ec, hl, pw};
  endfunction

  function automatic logic [17:0] obs();
    return {b.mem_read, b.mem_write, b.i_or_d, b.ir_write, b.alu_src_a, b.alu_src_b, b.alu_op,
            b.reg_write, b.mem_to_reg, b.pc_to_reg, b.pc_write, b.pc_src, b.is_ecall,
            b.is_halted, b.inst_retired};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp,
                     input logic [17:0] mask);
    vectors++;
    assert ((got & mask) === (exp & mask)) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got & mask, exp & mask);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit rdy, input logic [6:0] opc, input bit bc,
                      input bit eh, input logic [17:0] e, input logic [17:0] m, input bit ill);
    cyc_t c;
    c.tag = tag; c.ready = rdy; c.opc = opc; c.bc = bc; c.eh = eh;
    c.exp = e; c.mask = m; c.ill = ill;
    q.push_back(c);
  endtask

  function automatic bit r1();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  // Expected cycle sequence for one instruction, straight from the instruction-class rules.
  task automatic build(input logic [6:0] op, input int if_w, input int mem_w, input bit bc,
                       input bit eh);
    q.delete();
    for (int i = 0; i < if_w; i++)
      push("IF", 1'b0, r7(), r1(), r1(), ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0), ALL, 0);
    push("IF", 1'b1, r7(), r1(), r1(), ev(1,0,0,1,0,0,0,0,0,0,0,0,0,0), ALL, 0);
    case (op)
      R_OP, I_OP: begin
        push("ID", r1(), op, r1(), r1(), '0, ALL, 0);
        push("EX", r1(), r7(), r1(), r1(),
             ev(0,0,0,0,1,(op == I_OP) ? 2'b10 : 2'b00,2'b10,0,0,0,0,0,0,0), ALL, 0);
        push("WB", r1(), r7(), r1(), r1(), ev(0,0,0,0,0,0,0,1,0,0,1,0,0,0), ALL, 0);
      end
      LD, ST: begin
        push("ID", r1(), op, r1(), r1(), '0, ALL, 0);
        push("EX", r1(), r7(), r1(), r1(), ev(0,0,0,0,1,2'b10,0,0,0,0,0,0,0,0), ALL, 0);
        for (int i = 0; i < mem_w; i++)
          push("MEMW", 1'b0, r7(), r1(), r1(),
               ev(op == LD, op == ST, 1,0,0,0,0,0,0,0,0,0,0,0), ALL, 0);
        push("MEM", 1'b1, r7(), r1(), r1(),
             ev(op == LD, op == ST, 1,0,0,0,0,0,0,0, op == ST, 0,0,0), ALL, 0);
        if (op == LD)
          push("WB", r1(), r7(), r1(), r1(), ev(0,0,0,0,0,0,0,1,1,0,1,0,0,0), ALL, 0);
      end
      BR: begin
        push("ID", r1(), op, r1(), r1(), '0, ALL, 0);
        push("EX", r1(), r7(), bc, r1(),
             ev(0,0,0,0,1,0,2'b01,0,0,0,1, bc ? 2'b01 : 2'b00,0,0), ALL, 0);
      end
      JAL, JALR: begin
        push("ID", r1(), op, r1(), r1(), '0, ALL, 0);
        push("EX", r1(), r7(), r1(), r1(), '0, ALL & ~ALU, 0);
        push("WB", r1(), r7(), r1(), r1(),
             ev(0,0,0,0,0,0,0,1,0,1,1,(op == JAL) ? 2'b01 : 2'b10,0,0), ALL, 0);
      end
      SYS: begin
        push("ID", r1(), op, r1(), eh, ev(0,0,0,0,0,0,0,0,0,0,!eh,0,1,0), ALL, 0);
        if (eh)
          for (int i = 0; i < 20; i++)
            push("HALT", r1(), r7(), r1(), r1(), ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1), ALL, 0);
      end
      default: begin
`ifdef MC_ILLEGAL_TRAP_EN
        push("ILL", r1(), op, r1(), r1(), '0, ALL, 1);
        for (int i = 0; i < 20; i++)
          push("HALT", r1(), r7(), r1(), r1(), ev(0,0,0,0,0,0,0,0,0,0,0,0,0,1), ALL, 0);
`else
        push("NOP", r1(), op, r1(), r1(), ev(0,0,0,0,0,0,0,0,0,0,1,0,0,0), ALL, 0);
`endif
      end
    endcase
  endtask

  task automatic apply(input string name, input int n);
    for (int i = 0; i < q.size() && i < n; i++) begin
      @(negedge clk);
      b.opcode = q[i].opc;
      b.bcond = q[i].bc;
      b.ecall_halt = q[i].eh;
      b.mem_ready = q[i].ready;
      #1;
      chk({name, ".", q[i].tag}, obs(), q[i].exp, q[i].mask);
`ifdef MC_ILLEGAL_TRAP_EN
      chk_bit({name, ".illegal"}, b.illegal_inst, q[i].ill);
`endif
      chk_bit({name, ".excl"}, (b.mem_read & b.mem_write) | (b.reg_write & b.mem_write), 1'b0);
    end
  endtask

  task automatic run(input string name, input logic [6:0] op, input int if_w, input int mem_w,
                     input bit bc, input bit eh);
    build(op, if_w, mem_w, bc, eh);
    apply(name, q.size());
  endtask

  task automatic reset_pulse(input string name);
    @(negedge clk);
    #2;
    b.mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk({name, ".async"}, obs(), '0, ALL);
    @(negedge clk);
    chk({name, ".held"}, obs(), '0, ALL);
    reset_n = 1'b1;
    #1;
    chk({name, ".if"}, obs(), ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0), ALL);
  endtask

  logic [6:0] ops [8] = '{R_OP, I_OP, LD, ST, BR, JAL, JALR, SYS};

  initial begin
    b.opcode = '0; b.bcond = 1'b0; b.ecall_halt = 1'b0; b.mem_ready = 1'b0;
    #1;
    chk("reset", obs(), '0, ALL);
`ifdef MC_ILLEGAL_TRAP_EN
    chk_bit("reset.illegal", b.illegal_inst, 1'b0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_reset_if", obs(), ev(1,0,0,0,0,0,0,0,0,0,0,0,0,0), ALL);

    run("add", R_OP, 0, 0, 0, 0);
    run("lw", LD, 0, 2, 0, 0);
    run("beq_t", BR, 0, 0, 1, 0);
    run("beq_nt", BR, 1, 0, 0, 0);
    run("addi", I_OP, 2, 0, 0, 0);
    run("sw", ST, 1, 3, 0, 0);
    run("jal", JAL, 0, 0, 0, 0);
    run("jalr", JALR, 0, 0, 0, 0);
    run("ecall_go", SYS, 0, 0, 0, 0);

    // Abort a store while it is stalled in MEM.
    build(ST, 0, 6, 0, 0);
    apply("sw_abort", 5);
    reset_pulse("sw_abort_rst");

    run("illegal", 7'b0000000, 0, 0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    reset_pulse("illegal_rst");
`endif

    for (int n = 0; n < 120; n++) begin
      int k;
      k = $urandom_range(0, 7);
      run("rand", ops[k], $urandom_range(0, 3), $urandom_range(0, 3), r1(), 1'b0);
    end

    run("ecall_halt", SYS, 1, 0, 0, 1);
    reset_pulse("halt_rst");
    run("after_halt", R_OP, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
